fwd_select_unit: RTL

Forwarding-select generator for the dual-issue pipeline: the producer side of the 2-bit select that drives the operand `Mux4to1` instances in EX. It tracks destination registers of both issue slots through EX, MEM and WB, compares them against the source registers of the pair in ID, and registers one select code plus lane bit per operand (4 operands). The outputs are valid while that pair sits in EX. It also flags intra-pair RAW dependences so issue logic can split the pair.

---
 rtl/fwd_select_unit_pkg.sv | 25 ++
 rtl/fwd_match.sv | 40 ++++
 rtl/fwd_select_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/fwd_select_unit_pkg.sv
// Shared types for the forwarding-select generator: select encodings and the
// {valid, rd} tracker entry used by the top level and the per-operand matcher.
package fwd_select_unit_pkg;

  localparam int FWD_REG_W = 5;
  localparam int TRK_N     = 6;

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10,
    SEL_WBL   = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [FWD_REG_W-1:0] rd;
  } trk_entry_t;

  // valid already folds in regwrite; x0 is never a forwarding source
  function automatic logic trk_hit(input trk_entry_t e, input logic [FWD_REG_W-1:0] rs);
    return e.valid && (e.rd != '0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one source operand against the six tracker entries.
// Entry index is stage*2 + lane with stage 0 = EX, 1 = MEM, 2 = WB.
module fwd_match
  import fwd_select_unit_pkg::*;
(
  input  logic                       en,
  input  logic [FWD_REG_W-1:0]       rs,
  input  trk_entry_t [TRK_N-1:0]     trk,
  output fwd_sel_e                   sel,
  output logic                       lane
);

  logic [TRK_N-1:0] hit;

  always_comb begin
    for (int i = 0; i < TRK_N; i++) begin
      hit[i] = en && (rs != '0) && trk_hit(trk[i], rs);
    end
    sel  = SEL_RF;
    lane = 1'b0;
    // youngest stage first; within a stage lane 1 is younger
    if (hit[1]) begin
      sel  = SEL_EXMEM;
      lane = 1'b1;
    end else if (hit[0]) begin
      sel  = SEL_EXMEM;
    end else if (hit[3]) begin
      sel  = SEL_MEMWB;
      lane = 1'b1;
    end else if (hit[2]) begin
      sel  = SEL_MEMWB;
    end else if (hit[5]) begin
      sel  = SEL_WBL;
      lane = 1'b1;
    end else if (hit[4]) begin
      sel  = SEL_WBL;
    end
  end

endmodule

// File: rtl/fwd_select_unit.sv
// Dual-issue forwarding-select generator: tracks EX/MEM/WB destinations and
// registers a select code and producing lane for each of the four ID operands.
module fwd_select_unit
  import fwd_select_unit_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NSLOT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NSLOT-1:0]            id_valid,
  input  logic [NSLOT-1:0][REG_W-1:0] id_rs1,
  input  logic [NSLOT-1:0][REG_W-1:0] id_rs2,
  input  logic [NSLOT-1:0][REG_W-1:0] id_rd,
  input  logic [NSLOT-1:0]            id_regwrite,
  input  logic                        stall,
  input  logic                        flush,
  output logic [NSLOT-1:0][1:0]       ex_sel_rs1,
  output logic [NSLOT-1:0][1:0]       ex_sel_rs2,
  output logic [NSLOT-1:0]            ex_lane_rs1,
  output logic [NSLOT-1:0]            ex_lane_rs2,
  output logic                        pair_dep
);

  if (NSLOT != 2 || REG_W != FWD_REG_W) begin : g_bad_param
    $error("fwd_select_unit supports exactly two slots and the package register width");
  end

  logic                       kill;
  logic [TRK_N-1:0]           trk_vld;
  logic [TRK_N-1:0][REG_W-1:0] trk_rd;
  trk_entry_t [TRK_N-1:0]     trk;
  fwd_sel_e                   sel_rs1 [NSLOT];
  fwd_sel_e                   sel_rs2 [NSLOT];
  logic [NSLOT-1:0]           lane_rs1;
  logic [NSLOT-1:0]           lane_rs2;

  assign kill = stall | flush;

  assign pair_dep = id_valid[0] & id_valid[1] & id_regwrite[0] & (id_rd[0] != '0) &
                    ((id_rd[0] == id_rs1[1]) | (id_rd[0] == id_rs2[1]));

  always_comb begin
    for (int i = 0; i < TRK_N; i++) begin
      trk[i].valid = trk_vld[i];
      trk[i].rd    = trk_rd[i];
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    fwd_match u_rs1 (
      .en   (id_valid[g]),
      .rs   (id_rs1[g]),
      .trk  (trk),
      .sel  (sel_rs1[g]),
      .lane (lane_rs1[g])
    );
    fwd_match u_rs2 (
      .en   (id_valid[g]),
      .rs   (id_rs2[g]),
      .trk  (trk),
      .sel  (sel_rs2[g]),
      .lane (lane_rs2[g])
    );
  end

  // ID -> EX boundary: a killed pair enters EX as an invalid bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld <= '0;
    end else begin
      trk_vld <= {trk_vld[3:0], id_valid & id_regwrite & {NSLOT{~kill}}};
    end
  end

  always_ff @(posedge clk) begin
    trk_rd <= {trk_rd[3:0], id_rd};
  end

  // select registers: aligned with the pair now in EX
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      ex_sel_rs1  <= '0;
      ex_sel_rs2  <= '0;
      ex_lane_rs1 <= '0;
      ex_lane_rs2 <= '0;
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        ex_sel_rs1[s] <= sel_rs1[s];
        ex_sel_rs2[s] <= sel_rs2[s];
      end
      ex_lane_rs1 <= lane_rs1;
      ex_lane_rs2 <= lane_rs2;
    end
  end

endmodule
